pico_axi_wr_arbiter: RTL and testbench

Two-requester AXI write-channel arbiter that shares one AXI write port (AW + W) between slave ports s0 and s1. It feeds the slave side of the bus upsizer or any downstream AXI write slave. AW requests are granted round-robin into a registered output stage. W bursts are routed strictly in AW-grant order through an order FIFO.

---
 rtl/pico_axi_wr_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_pico_axi_wr_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pico_axi_wr_arbiter.sv
// ---------------------------------------------------------------------------
// pico_axi_wr_arbiter
//
// Purpose:
//   Shares one AXI write port (AW + W) between two requesters, s0 and s1.
//   AW requests are granted round-robin into a registered output stage.
//   The index of every granted port is pushed into a small order FIFO, and
//   the W channel is routed combinationally from the port at the FIFO head.
//   W bursts therefore leave in exactly the order their AWs were granted.
//
// Ports:
//   aclk, areset          clock (rising edge), asynchronous active-high reset
//   s0_axi_aw*, s1_axi_aw* AW channel of requester 0 / 1 (awready is comb.)
//   s0_axi_w*,  s1_axi_w*  W channel of requester 0 / 1 (wready is comb.)
//   m_axi_aw*             registered AW channel towards the slave
//   m_axi_w*              W channel towards the slave, muxed from FIFO head
//   order_count           number of granted AWs whose W burst is not done
//   idle                  no outstanding work and no pending AW request
// ---------------------------------------------------------------------------
module pico_axi_wr_arbiter #(
    parameter int C_AXI_ID_WIDTH   = 8,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 128,
    parameter int ORDER_DEPTH      = 4,
    parameter int LOG_ORDER_DEPTH  = 2
) (
    input  logic                            aclk,
    input  logic                            areset,

    input  logic                            s0_axi_awvalid,
    output logic                            s0_axi_awready,
    input  logic [C_AXI_ID_WIDTH-1:0]       s0_axi_awid,
    input  logic [C_AXI_ADDR_WIDTH-1:0]     s0_axi_awaddr,
    input  logic [7:0]                      s0_axi_awlen,
    input  logic [2:0]                      s0_axi_awsize,
    input  logic [1:0]                      s0_axi_awburst,
    input  logic [C_AXI_DATA_WIDTH-1:0]     s0_axi_wdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]   s0_axi_wstrb,
    input  logic                            s0_axi_wlast,
    input  logic                            s0_axi_wvalid,
    output logic                            s0_axi_wready,

    input  logic                            s1_axi_awvalid,
    output logic                            s1_axi_awready,
    input  logic [C_AXI_ID_WIDTH-1:0]       s1_axi_awid,
    input  logic [C_AXI_ADDR_WIDTH-1:0]     s1_axi_awaddr,
    input  logic [7:0]                      s1_axi_awlen,
    input  logic [2:0]                      s1_axi_awsize,
    input  logic [1:0]                      s1_axi_awburst,
    input  logic [C_AXI_DATA_WIDTH-1:0]     s1_axi_wdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]   s1_axi_wstrb,
    input  logic                            s1_axi_wlast,
    input  logic                            s1_axi_wvalid,
    output logic                            s1_axi_wready,

    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_AXI_ID_WIDTH-1:0]       m_axi_awid,
    output logic [C_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                      m_axi_awlen,
    output logic [2:0]                      m_axi_awsize,
    output logic [1:0]                      m_axi_awburst,
    output logic [C_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                            m_axi_wlast,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,

    output logic [LOG_ORDER_DEPTH:0]        order_count,
    output logic                            idle
);

    localparam int SW = C_AXI_DATA_WIDTH / 8;
    localparam logic [LOG_ORDER_DEPTH:0]   L_DEPTH   = (LOG_ORDER_DEPTH+1)'(ORDER_DEPTH);
    localparam logic [LOG_ORDER_DEPTH:0]   L_CNT_ONE = (LOG_ORDER_DEPTH+1)'(1);
    localparam logic [LOG_ORDER_DEPTH:0]   L_CNT_ZERO = (LOG_ORDER_DEPTH+1)'(0);
    localparam logic [LOG_ORDER_DEPTH-1:0] L_PTR_ONE = LOG_ORDER_DEPTH'(1);

    // Registered AW stage
    logic                           r_awvalid;
    logic [C_AXI_ID_WIDTH-1:0]      r_awid;
    logic [C_AXI_ADDR_WIDTH-1:0]    r_awaddr;
    logic [7:0]                     r_awlen;
    logic [2:0]                     r_awsize;
    logic [1:0]                     r_awburst;
    logic                           r_last_grant;

    // Order FIFO: one bit per entry holding the granted port index
    logic [ORDER_DEPTH-1:0]         r_order;
    logic [LOG_ORDER_DEPTH-1:0]     r_wr_ptr;
    logic [LOG_ORDER_DEPTH-1:0]     r_rd_ptr;
    logic [LOG_ORDER_DEPTH:0]       r_count;

    logic                           w_slot_free;
    logic                           w_grant_en;
    logic                           w_grant0;
    logic                           w_grant1;
    logic                           w_grant;
    logic                           w_empty;
    logic                           w_head;
    logic                           w_pop;

    // Space is judged on the registered count only, so a pop this cycle
    // does not open room for a grant this cycle.
    assign w_slot_free = ~r_awvalid | m_axi_awready;
    assign w_grant_en  = w_slot_free & (r_count < L_DEPTH);
    assign w_grant     = w_grant0 | w_grant1;
    assign w_empty     = (r_count == L_CNT_ZERO);
    assign w_head      = r_order[r_rd_ptr];
    assign w_pop       = m_axi_wvalid & m_axi_wready & m_axi_wlast;

    // Round-robin grant: a lone requester wins; on contention the port that
    // did not win last time wins now.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (w_grant_en) begin
            case ({s1_axi_awvalid, s0_axi_awvalid})
                2'b01:   w_grant0 = 1'b1;
                2'b10:   w_grant1 = 1'b1;
                2'b11: begin
                    if (r_last_grant) begin
                        w_grant0 = 1'b1;
                    end else begin
                        w_grant1 = 1'b1;
                    end
                end
                default: begin
                    w_grant0 = 1'b0;
                    w_grant1 = 1'b0;
                end
            endcase
        end else begin
            w_grant0 = 1'b0;
            w_grant1 = 1'b0;
        end
    end

    assign s0_axi_awready = w_grant0;
    assign s1_axi_awready = w_grant1;

    // W channel steering from the port at the order FIFO head
    always_comb begin
        m_axi_wvalid  = 1'b0;
        m_axi_wdata   = {C_AXI_DATA_WIDTH{1'b0}};
        m_axi_wstrb   = {SW{1'b0}};
        m_axi_wlast   = 1'b0;
        s0_axi_wready = 1'b0;
        s1_axi_wready = 1'b0;
        if (!w_empty) begin
            case (w_head)
                1'b0: begin
                    m_axi_wvalid  = s0_axi_wvalid;
                    m_axi_wdata   = s0_axi_wdata;
                    m_axi_wstrb   = s0_axi_wstrb;
                    m_axi_wlast   = s0_axi_wlast;
                    s0_axi_wready = m_axi_wready;
                end
                1'b1: begin
                    m_axi_wvalid  = s1_axi_wvalid;
                    m_axi_wdata   = s1_axi_wdata;
                    m_axi_wstrb   = s1_axi_wstrb;
                    m_axi_wlast   = s1_axi_wlast;
                    s1_axi_wready = m_axi_wready;
                end
                default: begin
                    m_axi_wvalid  = 1'b0;
                end
            endcase
        end else begin
            m_axi_wvalid = 1'b0;
        end
    end

    // AW output register: load on grant, drop valid once accepted
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_awvalid    <= 1'b0;
            r_awid       <= {C_AXI_ID_WIDTH{1'b0}};
            r_awaddr     <= {C_AXI_ADDR_WIDTH{1'b0}};
            r_awlen      <= 8'd0;
            r_awsize     <= 3'd0;
            r_awburst    <= 2'd0;
            r_last_grant <= 1'b1;
        end else if (w_grant) begin
            r_awvalid    <= 1'b1;
            r_awid       <= w_grant1 ? s1_axi_awid    : s0_axi_awid;
            r_awaddr     <= w_grant1 ? s1_axi_awaddr  : s0_axi_awaddr;
            r_awlen      <= w_grant1 ? s1_axi_awlen   : s0_axi_awlen;
            r_awsize     <= w_grant1 ? s1_axi_awsize  : s0_axi_awsize;
            r_awburst    <= w_grant1 ? s1_axi_awburst : s0_axi_awburst;
            r_last_grant <= w_grant1;
        end else if (m_axi_awready) begin
            r_awvalid    <= 1'b0;
        end else begin
            r_awvalid    <= r_awvalid;
        end
    end

    // Order FIFO: push granted index, pop on the last W beat of the head burst
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_order  <= {ORDER_DEPTH{1'b0}};
            r_wr_ptr <= {LOG_ORDER_DEPTH{1'b0}};
            r_rd_ptr <= {LOG_ORDER_DEPTH{1'b0}};
            r_count  <= L_CNT_ZERO;
        end else begin
            if (w_grant) begin
                r_order[r_wr_ptr] <= w_grant1;
                r_wr_ptr          <= r_wr_ptr + L_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
            end
            case ({w_grant, w_pop})
                2'b10:   r_count <= r_count + L_CNT_ONE;
                2'b01:   r_count <= r_count - L_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign m_axi_awvalid = r_awvalid;
    assign m_axi_awid    = r_awid;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awlen   = r_awlen;
    assign m_axi_awsize  = r_awsize;
    assign m_axi_awburst = r_awburst;
    assign order_count   = r_count;
    assign idle          = w_empty & ~r_awvalid & ~s0_axi_awvalid & ~s1_axi_awvalid;

endmodule

// File: tb/tb_pico_axi_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pico_axi_wr_arbiter
//
// Scoreboard bench: every expected AW and W beat is pushed to a queue when
// the stimulus is queued; a monitor pops and compares on each master-side
// handshake. Inputs change at posedge+1 (control) / posedge+2 (requesters),
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_pico_axi_wr_arbiter;

    localparam int IDW = 8;
    localparam int AW  = 32;
    localparam int DW  = 128;
    localparam int SW  = DW / 8;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } aw_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
    } w_t;

    logic           aclk = 1'b0;
    logic           areset;

    logic           aw_valid [2];
    logic           aw_ready [2];
    logic [IDW-1:0] aw_id    [2];
    logic [AW-1:0]  aw_addr  [2];
    logic [7:0]     aw_len   [2];
    logic [2:0]     aw_size  [2];
    logic [1:0]     aw_burst [2];
    logic [DW-1:0]  w_data   [2];
    logic [SW-1:0]  w_strb   [2];
    logic           w_last   [2];
    logic           w_valid  [2];
    logic           w_ready  [2];
    logic           w_en     [2];

    logic           m_awvalid;
    logic           m_awready;
    logic [IDW-1:0] m_awid;
    logic [AW-1:0]  m_awaddr;
    logic [7:0]     m_awlen;
    logic [2:0]     m_awsize;
    logic [1:0]     m_awburst;
    logic [DW-1:0]  m_wdata;
    logic [SW-1:0]  m_wstrb;
    logic           m_wlast;
    logic           m_wvalid;
    logic           m_wready;
    logic [2:0]     order_count;
    logic           idle;

    aw_t q_aw [2][$];
    w_t  q_w  [2][$];
    aw_t exp_aw [$];
    w_t  exp_w  [$];

    int  n_total = 0;
    int  n_bad   = 0;

    always #5 aclk = ~aclk;

    pico_axi_wr_arbiter dut (
        .aclk           (aclk),
        .areset         (areset),
        .s0_axi_awvalid (aw_valid[0]), .s0_axi_awready (aw_ready[0]),
        .s0_axi_awid    (aw_id[0]),    .s0_axi_awaddr  (aw_addr[0]),
        .s0_axi_awlen   (aw_len[0]),   .s0_axi_awsize  (aw_size[0]),
        .s0_axi_awburst (aw_burst[0]), .s0_axi_wdata   (w_data[0]),
        .s0_axi_wstrb   (w_strb[0]),   .s0_axi_wlast   (w_last[0]),
        .s0_axi_wvalid  (w_valid[0]),  .s0_axi_wready  (w_ready[0]),
        .s1_axi_awvalid (aw_valid[1]), .s1_axi_awready (aw_ready[1]),
        .s1_axi_awid    (aw_id[1]),    .s1_axi_awaddr  (aw_addr[1]),
        .s1_axi_awlen   (aw_len[1]),   .s1_axi_awsize  (aw_size[1]),
        .s1_axi_awburst (aw_burst[1]), .s1_axi_wdata   (w_data[1]),
        .s1_axi_wstrb   (w_strb[1]),   .s1_axi_wlast   (w_last[1]),
        .s1_axi_wvalid  (w_valid[1]),  .s1_axi_wready  (w_ready[1]),
        .m_axi_awvalid  (m_awvalid),   .m_axi_awready  (m_awready),
        .m_axi_awid     (m_awid),      .m_axi_awaddr   (m_awaddr),
        .m_axi_awlen    (m_awlen),     .m_axi_awsize   (m_awsize),
        .m_axi_awburst  (m_awburst),   .m_axi_wdata    (m_wdata),
        .m_axi_wstrb    (m_wstrb),     .m_axi_wlast    (m_wlast),
        .m_axi_wvalid   (m_wvalid),    .m_axi_wready   (m_wready),
        .order_count    (order_count),
        .idle           (idle)
    );

    // Single comparison point: counts and reports
    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input int p, input logic [7:0] id, input int b);
        return {96'h0, 8'(p), id, 8'(b), 8'hA5};
    endfunction

    function automatic logic [SW-1:0] beat_strb(input logic [7:0] id, input int b);
        return {id, 8'(b)} ^ 16'h5A5A;
    endfunction

    task automatic queue_aw(input int p, input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
        aw_t a;
        a.id = id; a.addr = addr; a.len = len;
        q_aw[p].push_back(a);
    endtask

    task automatic queue_w(input int p, input logic [7:0] id, input logic [7:0] len);
        w_t w;
        for (int b = 0; b <= int'(len); b++) begin
            w.data = beat_data(p, id, b);
            w.strb = beat_strb(id, b);
            w.last = (b == int'(len));
            q_w[p].push_back(w);
        end
    endtask

    task automatic expect_burst(input int p, input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
        aw_t a;
        w_t  w;
        a.id = id; a.addr = addr; a.len = len;
        exp_aw.push_back(a);
        for (int b = 0; b <= int'(len); b++) begin
            w.data = beat_data(p, id, b);
            w.strb = beat_strb(id, b);
            w.last = (b == int'(len));
            exp_w.push_back(w);
        end
    endtask

    task automatic burst(input int p, input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
        queue_aw(p, id, addr, len);
        queue_w(p, id, len);
        expect_burst(p, id, addr, len);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_drain(input string tag, input int max_cyc);
        logic done;
        done = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge aclk);
            done = (exp_aw.size() == 0) && (exp_w.size() == 0) &&
                   (q_aw[0].size() == 0) && (q_aw[1].size() == 0) &&
                   (q_w[0].size() == 0) && (q_w[1].size() == 0);
            if (done) break;
        end
        check_val(tag, 128'(done), 128'(1));
    endtask

    // Requester model: AW and W valid/payload for both ports
    initial begin : drv
        logic aw_hs [2];
        logic w_hs  [2];
        aw_t  ta;
        w_t   tw;
        for (int p = 0; p < 2; p++) begin
            aw_valid[p] = 1'b0; aw_id[p] = 8'h0; aw_addr[p] = 32'h0; aw_len[p] = 8'h0;
            aw_size[p] = 3'd0; aw_burst[p] = 2'd0; w_data[p] = 128'h0; w_strb[p] = 16'h0;
            w_last[p] = 1'b0; w_valid[p] = 1'b0;
        end
        forever begin
            @(negedge aclk);
            for (int p = 0; p < 2; p++) begin
                aw_hs[p] = aw_valid[p] & aw_ready[p];
                w_hs[p]  = w_valid[p] & w_ready[p];
            end
            @(posedge aclk);
            #2;
            for (int p = 0; p < 2; p++) begin
                if (areset) begin
                    aw_valid[p] = 1'b0;
                    w_valid[p]  = 1'b0;
                    q_aw[p].delete();
                    q_w[p].delete();
                end else begin
                    if (aw_hs[p]) aw_valid[p] = 1'b0;
                    if (!aw_valid[p] && q_aw[p].size() > 0) begin
                        ta = q_aw[p].pop_front();
                        aw_id[p] = ta.id; aw_addr[p] = ta.addr; aw_len[p] = ta.len;
                        aw_size[p] = 3'd4; aw_burst[p] = 2'b01;
                        aw_valid[p] = 1'b1;
                    end
                    if (w_hs[p]) w_valid[p] = 1'b0;
                    if (!w_valid[p] && w_en[p] && q_w[p].size() > 0) begin
                        tw = q_w[p].pop_front();
                        w_data[p] = tw.data; w_strb[p] = tw.strb; w_last[p] = tw.last;
                        w_valid[p] = 1'b1;
                    end
                end
            end
        end
    end

    // Master-side monitor: pops the scoreboard on every handshake
    aw_t e_aw;
    w_t  e_w;
    always @(negedge aclk) begin
        if (!areset) begin
            if (m_awvalid && m_awready) begin
                check_val("aw_expected", 128'(exp_aw.size() != 0), 128'(1));
                if (exp_aw.size() != 0) begin
                    e_aw = exp_aw.pop_front();
                    check_val("aw_id",   128'(m_awid),   128'(e_aw.id));
                    check_val("aw_addr", 128'(m_awaddr), 128'(e_aw.addr));
                    check_val("aw_len",  128'(m_awlen),  128'(e_aw.len));
                    check_val("aw_sizeburst", 128'({m_awsize, m_awburst}), 128'({3'd4, 2'b01}));
                end
            end
            if (m_wvalid && m_wready) begin
                check_val("w_expected", 128'(exp_w.size() != 0), 128'(1));
                if (exp_w.size() != 0) begin
                    e_w = exp_w.pop_front();
                    check_val("w_data", m_wdata, e_w.data);
                    check_val("w_strb", 128'(m_wstrb), 128'(e_w.strb));
                    check_val("w_last", 128'(m_wlast), 128'(e_w.last));
                end
            end
        end
    end

    initial begin : main
        logic found;
        areset    = 1'b1;
        m_awready = 1'b1;
        m_wready  = 1'b1;
        w_en[0]   = 1'b1;
        w_en[1]   = 1'b1;
        repeat (3) tick();
        areset = 1'b0;
        @(negedge aclk);
        check_val("rst_awvalid", 128'(m_awvalid), 128'(0));
        check_val("rst_awaddr",  128'(m_awaddr),  128'(0));
        check_val("rst_count",   128'(order_count), 128'(0));
        check_val("rst_awready", 128'({aw_ready[1], aw_ready[0]}), 128'(0));
        check_val("rst_wvalid",  128'(m_wvalid), 128'(0));
        check_val("rst_idle",    128'(idle), 128'(1));

        // Both ports contend, port 1 W offered first: grants alternate 0,1,...
        tick();
        w_en[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            queue_aw(0, 8'(8'h10 + k), 32'h2000 + 32'(k * 16), 8'd1);
            queue_w(0, 8'(8'h10 + k), 8'd1);
            queue_aw(1, 8'(8'h20 + k), 32'h3000 + 32'(k * 16), 8'd1);
            queue_w(1, 8'(8'h20 + k), 8'd1);
            expect_burst(0, 8'(8'h10 + k), 32'h2000 + 32'(k * 16), 8'd1);
            expect_burst(1, 8'(8'h20 + k), 32'h3000 + 32'(k * 16), 8'd1);
        end
        repeat (8) tick();
        @(negedge aclk);
        check_val("rr_full_count",  128'(order_count), 128'(4));
        check_val("rr_full_awrdy",  128'({aw_ready[1], aw_ready[0]}), 128'(0));
        check_val("rr_s1_wready",   128'(w_ready[1]), 128'(0));
        check_val("rr_m_wvalid",    128'(m_wvalid), 128'(0));
        tick();
        w_en[0] = 1'b1;
        wait_drain("rr_drain", 200);

        // Port 0 alone: 4-beat burst at 0x1000
        tick();
        burst(0, 8'h01, 32'h1000, 8'd3);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (aw_valid[0] && aw_ready[0]) begin
                found = 1'b1;
                break;
            end
        end
        check_val("p0_grant_seen", 128'(found), 128'(1));
        check_val("p0_count_pre",  128'(order_count), 128'(0));
        @(negedge aclk);
        check_val("p0_awvalid",    128'(m_awvalid), 128'(1));
        check_val("p0_awaddr",     128'(m_awaddr), 128'(32'h1000));
        check_val("p0_count_1",    128'(order_count), 128'(1));
        wait_drain("p0_drain", 50);
        @(negedge aclk);
        check_val("p0_count_0",    128'(order_count), 128'(0));

        // FIFO full with AW slot held busy; one pop must not unblock grants
        tick();
        w_en[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            burst(0, 8'(8'h30 + k), 32'h4000 + 32'(k * 4), 8'd0);
        end
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (order_count == 3'd4) begin
                m_awready = 1'b0;
                found = 1'b1;
                break;
            end
        end
        check_val("full_reached", 128'(found), 128'(1));
        burst(1, 8'h40, 32'h5000, 8'd0);
        repeat (3) tick();
        @(negedge aclk);
        check_val("full_count",   128'(order_count), 128'(4));
        check_val("full_awrdy",   128'({aw_ready[1], aw_ready[0]}), 128'(0));
        check_val("full_awvalid", 128'(m_awvalid), 128'(1));
        check_val("full_awid",    128'(m_awid), 128'(8'h33));
        tick();
        w_en[0] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (order_count == 3'd3) begin
                w_en[0] = 1'b0;
                found = 1'b1;
                break;
            end
        end
        check_val("pop_one_seen", 128'(found), 128'(1));
        repeat (2) tick();
        @(negedge aclk);
        check_val("pop_one_count", 128'(order_count), 128'(3));
        check_val("pop_one_awrdy", 128'(aw_ready[1]), 128'(0));
        tick();
        m_awready = 1'b1;
        w_en[0]   = 1'b1;
        wait_drain("full_drain", 100);

        // Port 1 W ahead of its AW
        tick();
        queue_w(1, 8'h50, 8'd1);
        repeat (5) tick();
        @(negedge aclk);
        check_val("early_w_ready",  128'(w_ready[1]), 128'(0));
        check_val("early_m_wvalid", 128'(m_wvalid), 128'(0));
        check_val("early_count",    128'(order_count), 128'(0));
        tick();
        queue_aw(1, 8'h50, 32'h6000, 8'd1);
        expect_burst(1, 8'h50, 32'h6000, 8'd1);
        wait_drain("early_drain", 50);

        // 8-beat burst with master wready toggling
        tick();
        burst(0, 8'h60, 32'h7000, 8'd7);
        for (int i = 0; i < 80; i++) begin
            tick();
            m_wready = ~m_wready;
            if (exp_w.size() == 0) break;
        end
        m_wready = 1'b1;
        wait_drain("toggle_drain", 50);

        // Reset in the middle of a burst with two bursts outstanding
        tick();
        m_wready = 1'b0;
        burst(0, 8'h70, 32'h8000, 8'd3);
        burst(0, 8'h71, 32'h8100, 8'd3);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (order_count == 3'd2) begin
                found = 1'b1;
                break;
            end
        end
        check_val("rst_mid_count2", 128'(found), 128'(1));
        m_wready = 1'b1;
        tick();
        areset = 1'b1;
        #1;
        check_val("rst_mid_awvalid", 128'(m_awvalid), 128'(0));
        check_val("rst_mid_wvalid",  128'(m_wvalid), 128'(0));
        check_val("rst_mid_count",   128'(order_count), 128'(0));
        exp_aw.delete();
        exp_w.delete();
        repeat (2) tick();
        areset = 1'b0;
        tick();
        burst(1, 8'h81, 32'h9100, 8'd0);
        burst(0, 8'h80, 32'h9000, 8'd0);
        // expectation order: port 0 first after reset
        exp_aw.delete();
        exp_w.delete();
        expect_burst(0, 8'h80, 32'h9000, 8'd0);
        expect_burst(1, 8'h81, 32'h9100, 8'd0);
        @(negedge aclk);
        check_val("post_rst_grant0", 128'(aw_ready[0]), 128'(1));
        check_val("post_rst_grant1", 128'(aw_ready[1]), 128'(0));
        wait_drain("post_rst_drain", 50);
        repeat (2) tick();
        @(negedge aclk);
        check_val("end_idle",  128'(idle), 128'(1));
        check_val("end_count", 128'(order_count), 128'(0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
